unified_mem_arbiter: RTL
========================

UNIFIED_MEM_ARBITER -- requirements
Module: unified_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte address width of all ports.
REQ-002 SHALL have parameter MAX_DATA_BURST, default 4, maximum consecutive data grants while fetch waits.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports imem_req_i input 1, imem_addr_i input ADDR_WIDTH: fetch request and address.
REQ-006 SHALL have ports imem_gnt_o output 1, imem_rvalid_o output 1, imem_rdata_o output DATA_WIDTH: fetch accept, response valid, instruction word.
REQ-007 SHALL have ports dmem_req_i input 1, dmem_we_i input 1, dmem_be_i input 4, dmem_addr_i input ADDR_WIDTH, dmem_wdata_i input DATA_WIDTH: load/store request.
REQ-008 SHALL have ports dmem_gnt_o output 1, dmem_rvalid_o output 1, dmem_rdata_o output DATA_WIDTH: load/store accept, completion (read data or write ack), load data.
REQ-009 SHALL have ports mem_req_o output 1, mem_we_o output 1, mem_be_o output 4, mem_addr_o output ADDR_WIDTH, mem_wdata_o output DATA_WIDTH: single-port memory request.
REQ-010 SHALL have ports mem_gnt_i input 1, mem_rvalid_i input 1, mem_rdata_i input DATA_WIDTH: memory accept, response valid, read data.
REQ-011 SHALL have port flush_i input 1: pipeline flush from EX; squashes fetch traffic.

Function
REQ-012 SHALL be a 3-state FSM: ARB_IDLE, ARB_REQ, ARB_RESP; one memory transaction outstanding at most.
REQ-013 In ARB_IDLE with any eligible request, SHALL assert exactly one of imem_gnt_o/dmem_gnt_o combinationally, latch that requester's address/we/be/wdata and owner, go to ARB_REQ.
REQ-014 Priority SHALL be data over fetch, except fetch wins when both request and burst_cnt == MAX_DATA_BURST.
REQ-015 burst_cnt SHALL increment on a data grant with imem_req_i high, clear on a fetch grant or a data grant with imem_req_i low, never exceed MAX_DATA_BURST.
REQ-016 imem_req_i SHALL be ineligible in any cycle where flush_i is high.
REQ-017 mem_req_o SHALL be high exactly while in ARB_REQ, with mem_* driven from latched registers; fetch requests drive mem_we_o=0, mem_be_o=4'hF.
REQ-018 ARB_REQ SHALL hold request stable until mem_gnt_i, then go to ARB_RESP.
REQ-019 In ARB_RESP, mem_rvalid_i SHALL pulse owner's rvalid_o the same cycle (combinational), rdata_o = mem_rdata_i, FSM returns to ARB_IDLE; next arbitration the following cycle.
REQ-020 Minimum latency: gnt cycle N, mem_req_o cycle N+1, rvalid_o cycle N+2 when memory grants and responds immediately.
REQ-021 flush_i high while owner is fetch in ARB_REQ or ARB_RESP SHALL set a squash flag; memory transaction still completes, imem_rvalid_o suppressed; flag clears on return to ARB_IDLE.
REQ-022 flush_i coincident with mem_rvalid_i for a fetch SHALL suppress imem_rvalid_o.
REQ-023 flush_i SHALL never affect a data-owned transaction.
REQ-024 rvalid_o of the non-owner SHALL stay 0; mem_rvalid_i outside ARB_RESP SHALL be ignored.
REQ-025 rdata_o outputs SHALL be 0 when the corresponding rvalid_o is 0.

Reset
REQ-026 rst_n low SHALL immediately force ARB_IDLE, owner OWN_NONE, burst_cnt 0, squash 0, latched request fields 0.
REQ-027 During and after reset all outputs SHALL be 0 until a new grant; a transaction in flight at reset is abandoned with no rvalid_o.

Structure
REQ-028 arb_state_e {ARB_IDLE, ARB_REQ, ARB_RESP} and arb_owner_e {OWN_NONE, OWN_INSTR, OWN_DATA} SHALL live in core_pkg; DATA_WIDTH from core_pkg.
REQ-029 SHALL be a single module, no sub-modules; priority select inline.

Verification
REQ-030 Both idle, imem_req_i at addr 0x100, mem grants/responds immediately with 0x00000013 -> imem_gnt_o cycle 0, mem_req_o cycle 1, imem_rvalid_o with 0x00000013 cycle 2.
REQ-031 imem and dmem (load 0x2000) requesting same cycle -> dmem_gnt_o only; fetch granted in next ARB_IDLE.
REQ-032 dmem_req_i and imem_req_i held continuously -> exactly 4 data grants, then 1 fetch grant, pattern repeats.
REQ-033 Store we=1 be=4'b0011 data 0xDEADBEEF, mem_gnt_i delayed 3 cycles -> mem_* stable 3 cycles, dmem_rvalid_o on mem_rvalid_i.
REQ-034 flush_i pulsed in ARB_RESP of fetch -> no imem_rvalid_o, FSM to ARB_IDLE after mem_rvalid_i, next request served normally.
REQ-035 rst_n low in ARB_REQ -> outputs 0 immediately, no rvalid_o, fresh arbitration after release.

Source files
------------

// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_pkg
// Description : Shared core types: data width and the unified memory
//               arbiter's state and owner encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

    localparam int DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_INSTR = 2'd1,
        OWN_DATA  = 2'd2
    } arb_owner_e;

endpackage
`default_nettype wire

// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : unified_mem_arbiter
// Description : Shares one single-port memory between instruction fetch and
//               load/store. Data has priority, but fetch is forced in after
//               MAX_DATA_BURST back-to-back data grants. A single transaction
//               is outstanding at a time; flush squashes fetch responses.
// Revision    : 1.0 - initial release
// ============================================================================
module unified_mem_arbiter
    import core_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int MAX_DATA_BURST = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // instruction fetch port
    input  logic                  imem_req_i,
    input  logic [ADDR_WIDTH-1:0] imem_addr_i,
    output logic                  imem_gnt_o,
    output logic                  imem_rvalid_o,
    output logic [DATA_WIDTH-1:0] imem_rdata_o,
    // load/store port
    input  logic                  dmem_req_i,
    input  logic                  dmem_we_i,
    input  logic [3:0]            dmem_be_i,
    input  logic [ADDR_WIDTH-1:0] dmem_addr_i,
    input  logic [DATA_WIDTH-1:0] dmem_wdata_i,
    output logic                  dmem_gnt_o,
    output logic                  dmem_rvalid_o,
    output logic [DATA_WIDTH-1:0] dmem_rdata_o,
    // memory port
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [3:0]            mem_be_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    // pipeline flush
    input  logic                  flush_i
);

    localparam int                 c_cnt_w     = $clog2(MAX_DATA_BURST + 1);
    localparam logic [c_cnt_w-1:0] c_burst_max = c_cnt_w'(MAX_DATA_BURST);

    arb_state_e            r_state;
    arb_owner_e            r_owner;
    logic [c_cnt_w-1:0]    r_burst_cnt;
    logic                  r_squash;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_we;
    logic [3:0]            r_be;
    logic [DATA_WIDTH-1:0] r_wdata;

    logic w_idle;
    logic w_imem_elig;
    logic w_burst_full;
    logic w_pick_data;
    logic w_pick_instr;
    logic w_gnt_data;
    logic w_gnt_instr;
    logic w_resp;

    // A flushed fetch is not a candidate; fetch wins only once data has had its full burst.
    assign w_idle       = (r_state == ARB_IDLE);
    assign w_imem_elig  = imem_req_i & ~flush_i;
    assign w_burst_full = (r_burst_cnt == c_burst_max);
    assign w_pick_data  = dmem_req_i & ~(w_imem_elig & w_burst_full);
    assign w_pick_instr = w_imem_elig & ~w_pick_data;
    // Grants are gated by rst_n so nothing is accepted while reset is held.
    assign w_gnt_data   = w_idle & rst_n & w_pick_data;
    assign w_gnt_instr  = w_idle & rst_n & w_pick_instr;
    assign w_resp       = (r_state == ARB_RESP) & mem_rvalid_i;

    // Sequence each transaction and capture the winning requester's fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ARB_IDLE;
            r_owner <= OWN_NONE;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_be    <= 4'h0;
            r_wdata <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_gnt_data) begin
                        r_state <= ARB_REQ;
                        r_owner <= OWN_DATA;
                        r_addr  <= dmem_addr_i;
                        r_we    <= dmem_we_i;
                        r_be    <= dmem_be_i;
                        r_wdata <= dmem_wdata_i;
                    end else if (w_gnt_instr) begin
                        r_state <= ARB_REQ;
                        r_owner <= OWN_INSTR;
                        r_addr  <= imem_addr_i;
                        r_we    <= 1'b0;
                        r_be    <= 4'hF;
                        r_wdata <= '0;
                    end
                end
                ARB_REQ: begin
                    if (mem_gnt_i) begin
                        r_state <= ARB_RESP;
                    end
                end
                ARB_RESP: begin
                    if (mem_rvalid_i) begin
                        r_state <= ARB_IDLE;
                        r_owner <= OWN_NONE;
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                    r_owner <= OWN_NONE;
                end
            endcase
        end
    end

    // Count data grants that made a waiting fetch stand aside, saturating at the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_burst_cnt <= '0;
        end else if (w_gnt_instr) begin
            r_burst_cnt <= '0;
        end else if (w_gnt_data) begin
            if (!imem_req_i) begin
                r_burst_cnt <= '0;
            end else if (!w_burst_full) begin
                r_burst_cnt <= r_burst_cnt + 1'b1;
            end
        end
    end

    // Remember a flush seen during an in-flight fetch so its response is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_squash <= 1'b0;
        end else if (w_resp) begin
            r_squash <= 1'b0;
        end else if ((r_owner == OWN_INSTR) && !w_idle && flush_i) begin
            r_squash <= 1'b1;
        end
    end

    assign imem_gnt_o    = w_gnt_instr;
    assign dmem_gnt_o    = w_gnt_data;

    assign mem_req_o     = (r_state == ARB_REQ);
    assign mem_we_o      = r_we;
    assign mem_be_o      = r_be;
    assign mem_addr_o    = r_addr;
    assign mem_wdata_o   = r_wdata;

    // A flush in the response cycle itself also kills the fetch response.
    assign imem_rvalid_o = w_resp & (r_owner == OWN_INSTR) & ~r_squash & ~flush_i;
    assign dmem_rvalid_o = w_resp & (r_owner == OWN_DATA);
    assign imem_rdata_o  = imem_rvalid_o ? mem_rdata_i : '0;
    assign dmem_rdata_o  = dmem_rvalid_o ? mem_rdata_i : '0;

endmodule
`default_nettype wire
